// File: rtl/bramac_pkg.sv
// Shared definitions for the BrAMAC job scheduler: instruction word layout,
// mode encodings, precision lookup and the scheduler state enum.
// DWIDTH (instruction word width) falls back to 40 when no defines file set it.
`ifndef DWIDTH
`define DWIDTH 40
`endif

package bramac_pkg;

    // Instruction word bit positions
    localparam int INST_RESET   = 24;
    localparam int INST_START   = 23;
    localparam int INST_DONE    = 22;
    localparam int INST_COPY    = 21;
    localparam int INST_MODE_LO = 19;
    localparam int INST_ROW_LO  = 12;
    localparam int INST_COL1_LO = 10;
    localparam int INST_COL2_LO = 8;
    localparam int INST_IN_LO   = 0;

    // Field widths
    localparam int MODE_W = 2;
    localparam int ROW_W  = 7;
    localparam int COL_W  = 2;
    localparam int IN_W   = 8;

    typedef enum logic [1:0] {
        MODE_ILL = 2'b00,
        MODE_2B  = 2'b01,
        MODE_4B  = 2'b10,
        MODE_8B  = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_START, S_MODE, S_W1, S_W2, S_RUN, S_READ, S_CLR
    } state_e;

    // Operand precision in bits for a mode; 0 for the illegal encoding
    function automatic logic [3:0] prec(input logic [1:0] m);
        case (m)
            MODE_2B: prec = 4'd2;
            MODE_4B: prec = 4'd4;
            MODE_8B: prec = 4'd8;
            default: prec = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bramac_act_fifo.sv
// Show-ahead synchronous activation FIFO with occupancy count.
// dout_o always presents the head entry; push is dropped when full and
// pop is dropped when empty.
module bramac_act_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (cnt_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        nxt = (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    // Storage write; contents need no reset since count gates validity
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // Pointer and occupancy update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/bramac_job_sched.sv
// BrAMAC job scheduler: buffers activations, then sequences one MAC job
// into the cycle-exact 40-bit BrAMAC instruction stream.
// Optional: define BRAMAC_SCHED_PERF_EN to add perf_cycles/perf_stall counters.
module bramac_job_sched
    import bramac_pkg::*;
#(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4,
    parameter int READ_CYC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [1:0]         job_mode,
    input  logic [6:0]         job_row,
    input  logic [1:0]         job_col1,
    input  logic [1:0]         job_col2,
    input  logic [ITER_W-1:0]  job_niter,
    input  logic               act_valid,
    output logic               act_ready,
    input  logic [7:0]         act_data,
    output logic               comp_en,
    output logic [`DWIDTH-1:0] inst,
    output logic               result_valid,
    output logic               busy,
    output logic               job_err
`ifdef BRAMAC_SCHED_PERF_EN
    ,
    output logic [15:0]        perf_cycles,
    output logic [15:0]        perf_stall
`endif
);

    localparam int DEPTH = 2 * MAX_ITER;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int RW    = (READ_CYC > 1) ? $clog2(READ_CYC) : 1;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, col1_q, col2_q;
    logic [6:0]        row_q;
    logic [ITER_W-1:0] niter_q, k_q;
    logic [3:0]        c_q;
    logic [RW-1:0]     rd_q;
    logic              err_q;

    logic [CW-1:0]     fifo_cnt;
    logic [7:0]        fifo_dout;
    logic              fifo_full, pop;
    logic              job_xfer, legal, enough, last, is_add, is_acc, rd_last;
    logic [3:0]        p_bits;
    logic [6:0]        row_nxt;

    bramac_act_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (act_valid),
        .pop_i   (pop),
        .din_i   (act_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign job_xfer  = job_valid && job_ready;
    assign legal     = (job_mode != MODE_ILL) && (job_niter != '0) &&
                       ({{(32-ITER_W){1'b0}}, job_niter} <= 32'(MAX_ITER));
    assign enough    = {{(32-CW){1'b0}}, fifo_cnt} >= {{(31-ITER_W){1'b0}}, niter_q, 1'b0};
    assign p_bits    = prec(mode_q);
    assign last      = (k_q == niter_q - ITER_W'(1));
    assign is_add    = (state_q == S_RUN) && (c_q == p_bits + 4'd1);
    assign is_acc    = (state_q == S_RUN) && (c_q == p_bits + 4'd2);
    assign rd_last   = (rd_q == RW'(READ_CYC - 1));
    // W1 row of the next iteration; 7-bit wrap is intentional
    assign row_nxt   = row_q + 7'({k_q, 1'b0}) + 7'd2;

    assign job_ready = (state_q == S_IDLE);
    assign act_ready = !fifo_full;
    assign job_err   = err_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (job_xfer && legal) state_d = S_FILL;
            S_FILL:  if (enough) state_d = S_START;
            S_START: state_d = S_MODE;
            S_MODE:  state_d = S_W1;
            S_W1:    state_d = S_W2;
            S_W2:    state_d = S_RUN;
            S_RUN:   if (is_acc && last) state_d = S_READ;
            S_READ:  if (rd_last) state_d = S_CLR;
            S_CLR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: instruction word, FIFO pop and status flags
    always_comb begin
        inst         = '0;
        pop          = 1'b0;
        busy         = (state_q != S_IDLE) && (state_q != S_FILL);
        comp_en      = busy;
        result_valid = (state_q == S_READ);
        if (busy) begin
            inst[INST_MODE_LO +: MODE_W] = mode_q;
            inst[INST_COL1_LO +: COL_W]  = col1_q;
            inst[INST_COL2_LO +: COL_W]  = col2_q;
        end
        case (state_q)
            S_START: inst[INST_START] = 1'b1;
            S_W1, S_W2: begin
                pop = 1'b1;
                inst[INST_ROW_LO +: ROW_W] = (state_q == S_W2) ? row_q + 7'd1 : row_q;
                inst[INST_IN_LO +: IN_W]   = fifo_dout;
            end
            S_RUN: begin
                if ((is_add || is_acc) && !last) begin
                    pop = 1'b1;
                    inst[INST_COPY] = 1'b1;
                    inst[INST_ROW_LO +: ROW_W] = is_acc ? row_nxt + 7'd1 : row_nxt;
                    inst[INST_IN_LO +: IN_W]   = fifo_dout;
                end
                if (is_acc && last) inst[INST_DONE] = 1'b1;
            end
            S_CLR:   inst[INST_RESET] = 1'b1;
            default: ;
        endcase
    end

    // Descriptor latch, reject pulse and iteration/cycle/readout counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= '0;
            row_q   <= '0;
            col1_q  <= '0;
            col2_q  <= '0;
            niter_q <= '0;
            k_q     <= '0;
            c_q     <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= job_xfer && !legal;
            if (job_xfer && legal) begin
                mode_q  <= job_mode;
                row_q   <= job_row;
                col1_q  <= job_col1;
                col2_q  <= job_col2;
                niter_q <= job_niter;
            end
            if (state_q == S_W2) begin
                c_q <= '0;
                k_q <= '0;
            end else if (state_q == S_RUN) begin
                if (is_acc && !last) begin
                    c_q <= '0;
                    k_q <= k_q + ITER_W'(1);
                end else begin
                    c_q <= c_q + 4'd1;
                end
            end
            rd_q <= (state_q == S_READ) ? rd_q + RW'(1) : '0;
        end
    end

`ifdef BRAMAC_SCHED_PERF_EN
    logic [15:0] run_q, cyc_q, stall_q;
    assign perf_cycles = cyc_q;
    assign perf_stall  = stall_q;

    // Accept-to-readout latency and fill-stall counters, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= '0;
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (job_xfer && legal) begin
                run_q   <= 16'd1;
                stall_q <= '0;
            end else if (busy || state_q == S_FILL) begin
                if (run_q != 16'hFFFF) run_q <= run_q + 16'd1;
            end
            if (state_q == S_FILL && !enough && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (state_q == S_READ && rd_q == '0)
                cyc_q <= run_q;
        end
    end
`endif

endmodule

// File: tb/tb_bramac_job_sched.sv
// Self-checking bench for bramac_job_sched: a reference model expands each
// accepted job into its expected per-cycle instruction words and queues them;
// the DUT stream is popped and compared once the start bit appears.
module tb_bramac_job_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [1:0]  job_mode = '0;
    logic [6:0]  job_row = '0;
    logic [1:0]  job_col1 = '0;
    logic [1:0]  job_col2 = '0;
    logic [3:0]  job_niter = '0;
    logic        act_valid = 1'b0;
    logic        act_ready;
    logic [7:0]  act_data = '0;
    logic        comp_en;
    logic [39:0] inst;
    logic        result_valid;
    logic        busy;
    logic        job_err;
`ifdef BRAMAC_SCHED_PERF_EN
    logic [15:0] perf_cycles, perf_stall;
`endif

    bramac_job_sched #(.MAX_ITER(8), .ITER_W(4), .READ_CYC(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_mode     (job_mode),
        .job_row      (job_row),
        .job_col1     (job_col1),
        .job_col2     (job_col2),
        .job_niter    (job_niter),
        .act_valid    (act_valid),
        .act_ready    (act_ready),
        .act_data     (act_data),
        .comp_en      (comp_en),
        .inst         (inst),
        .result_valid (result_valid),
        .busy         (busy),
        .job_err      (job_err)
`ifdef BRAMAC_SCHED_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] w;
        logic        rv;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] act_model[$];
    int         nchk = 0;
    int         npass = 0;
    int         acc_cyc = 0;
    bit         stream_en = 1'b0;
    logic [7:0] stream_val = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock; optionally keeps streaming activations whenever accepted
    task automatic tick();
        if (stream_en) begin
            if (act_ready) begin
                act_valid = 1'b1;
                act_data  = stream_val;
                act_model.push_back(stream_val);
                stream_val = stream_val + 8'd1;
            end else begin
                act_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        act_valid = 1'b1;
        act_data  = b;
        if (act_ready) act_model.push_back(b);
        @(posedge clk);
        #1;
        act_valid = 1'b0;
    endtask

    task automatic accept(input logic [1:0] m, input logic [6:0] r,
                          input logic [1:0] a, input logic [1:0] b, input logic [3:0] n);
        chk("job_ready_before", {63'd0, job_ready}, 64'd1);
        job_valid = 1'b1;
        job_mode  = m;
        job_row   = r;
        job_col1  = a;
        job_col2  = b;
        job_niter = n;
        acc_cyc   = cyc;
        tick();
        job_valid = 1'b0;
    endtask

    function automatic logic [7:0] take();
        if (act_model.size() == 0) return 8'h00;
        return act_model.pop_front();
    endfunction

    function automatic logic [39:0] mk(input logic [39:0] base, input logic [6:0] row,
                                       input logic [7:0] din);
        logic [39:0] w;
        w = base;
        w[18:12] = row;
        w[7:0]   = din;
        return w;
    endfunction

    // Reference expansion of one job into its per-cycle instruction words
    task automatic gen_job(input logic [1:0] m, input logic [6:0] r,
                           input logic [1:0] a, input logic [1:0] b, input int n);
        int          p;
        exp_t        e;
        logic [39:0] base;
        logic [6:0]  rr;
        p = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 8;
        base = '0;
        base[20:19] = m;
        base[11:10] = a;
        base[9:8]   = b;
        e.rv = 1'b0;
        e.w = base; e.w[23] = 1'b1;           exp_q.push_back(e);
        e.w = base;                           exp_q.push_back(e);
        e.w = mk(base, r, take());            exp_q.push_back(e);
        e.w = mk(base, 7'(r + 1), take());    exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < p + 3; c++) begin
                rr = 7'(r + 2 * (k + 1));
                e.w = base;
                if (c == p + 1 && k < n - 1) begin
                    e.w = mk(base, rr, take());
                    e.w[21] = 1'b1;
                end else if (c == p + 2) begin
                    if (k < n - 1) begin
                        e.w = mk(base, 7'(rr + 1), take());
                        e.w[21] = 1'b1;
                    end else begin
                        e.w[22] = 1'b1;
                    end
                end
                exp_q.push_back(e);
            end
        end
        e.w = base; e.rv = 1'b1;             exp_q.push_back(e);
        e.w = base; e.w[24] = 1'b1; e.rv = 1'b0; exp_q.push_back(e);
    endtask

    // Wait (bounded) for start, then compare every cycle of the job
    task automatic check_job(input int exp_start, input int exp_ready);
        exp_t e;
        for (int i = 0; i < 200 && !inst[23]; i++) tick();
        if (!inst[23]) begin
            chk("start_timeout", {63'd0, inst[23]}, 64'd1);
            exp_q.delete();
            return;
        end
        if (exp_start >= 0) chk("start_lat", 64'(cyc - acc_cyc), 64'(exp_start));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("inst_cycle", {21'd0, busy, comp_en, e.rv ? result_valid : result_valid, inst},
                {21'd0, 1'b1, 1'b1, e.rv, e.w});
            tick();
        end
        chk("idle_after", {22'd0, job_ready, busy, inst}, {22'd0, 1'b1, 1'b0, 40'd0});
        if (exp_ready >= 0) chk("ready_lat", 64'(cyc - acc_cyc), 64'(exp_ready));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1;
        chk("reset_state", {57'd0, inst == 40'd0, comp_en, result_valid, busy, job_err, job_ready, act_ready},
            {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // Directed job: mode 4b, row 10, N=2, preloaded activations
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        accept(2'b10, 7'd10, 2'd1, 2'd2, 4'd2);
        gen_job(2'b10, 7'd10, 2'd1, 2'd2, 2);
        check_job(2, 22);

        // Rejected descriptors: mode 00, N=0, N>MAX_ITER
        push_byte(8'hA1); push_byte(8'hA2);
        for (int i = 0; i < 3; i++) begin
            accept((i == 0) ? 2'b00 : 2'b01, 7'd3, 2'd0, 2'd0,
                   (i == 0) ? 4'd3 : (i == 1) ? 4'd0 : 4'd9);
            chk("err_pulse", {22'd0, job_err, busy, inst}, {22'd0, 1'b1, 1'b0, 40'd0});
            tick();
            chk("err_clear", {62'd0, job_err, job_ready}, {62'd0, 1'b0, 1'b1});
        end
        // FIFO untouched by rejects: the preloaded pair feeds a 2b, N=1 job
        accept(2'b01, 7'd20, 2'd3, 2'd0, 4'd1);
        gen_job(2'b01, 7'd20, 2'd3, 2'd0, 1);
        check_job(2, -1);

        // 8b, N=1 with activations arriving late: held in fill
        accept(2'b11, 7'd40, 2'd2, 2'd1, 4'd1);
        for (int i = 0; i < 9; i++) begin
            chk("fill_hold", {22'd0, busy, job_ready, inst}, {22'd0, 1'b0, 1'b0, 40'd0});
            tick();
        end
        push_byte(8'h5A); push_byte(8'hA5);
        gen_job(2'b11, 7'd40, 2'd2, 2'd1, 1);
        check_job(13, -1);

        // Row wrap: base 126, W2 of iteration 1 lands on row 1
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        accept(2'b01, 7'd126, 2'd0, 2'd3, 4'd2);
        gen_job(2'b01, 7'd126, 2'd0, 2'd3, 2);
        check_job(2, -1);

        // Reset asserted mid-run
        push_byte(8'h61); push_byte(8'h62); push_byte(8'h63); push_byte(8'h64);
        accept(2'b10, 7'd50, 2'd1, 2'd1, 4'd2);
        for (int i = 0; i < 40 && (cyc - acc_cyc) < 8; i++) tick();
        reset = 1'b1;
        #1;
        chk("async_reset", {23'd0, comp_en, busy, job_ready, inst[38:0] == 39'd0 ? inst : inst},
            {23'd0, 1'b0, 1'b0, 1'b1, 40'd0});
        chk("fifo_flushed", 64'(dut.u_fifo.count_o), 64'd0);
        act_model.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {62'd0, job_ready, act_ready}, {62'd0, 1'b1, 1'b1});

        // Full FIFO with concurrent push/pop during a job; order must hold
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        chk("fifo_full", {63'd0, act_ready}, 64'd0);
        stream_val = 8'hC0;
        stream_en  = 1'b1;
        accept(2'b01, 7'd5, 2'd2, 2'd2, 4'd2);
        gen_job(2'b01, 7'd5, 2'd2, 2'd2, 2);
        check_job(2, -1);
        stream_en = 1'b0;
        act_valid = 1'b0;
        tick();
        chk("fifo_count", 64'(dut.u_fifo.count_o), 64'(act_model.size()));
        begin
            int n2;
            n2 = act_model.size() / 2;
            if (n2 > 8) n2 = 8;
            if (n2 < 1) n2 = 1;
            accept(2'b10, 7'd70, 2'd1, 2'd0, 4'(n2));
            gen_job(2'b10, 7'd70, 2'd1, 2'd0, n2);
            check_job(2, -1);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
